jtag_tap_oversampled: RTL and testbench
=======================================

JTAG_TAP_OVERSAMPLED -- requirements
Module: jtag_tap_oversampled

Interface
REQ-001 Parameter IDCODE_VALUE, default 32'h2495_11C3, value loaded into the IDCODE data register on Capture-DR.
REQ-002 Parameter SYNC_STAGES, default 2, number of synchronizer flops on jtag_tck, jtag_tms, jtag_tdi and jtag_trst.
REQ-003 Parameter USER_DR_W, default 41, width of the user (DMI-shaped) data register.
REQ-004 clk_in  input  1  single block clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low block reset.
REQ-006 jtag_tck  input  1  JTAG test clock, treated as data and oversampled by clk_in.
REQ-007 jtag_tms  input  1  JTAG mode select.
REQ-008 jtag_tdi  input  1  JTAG serial data in.
REQ-009 jtag_trst  input  1  JTAG reset, active-low.
REQ-010 jtag_tdo  output  1  JTAG serial data out.
REQ-011 jtag_tdo_oe  output  1  high only while the TAP is in Shift-IR or Shift-DR.
REQ-012 user_capture_data  input  USER_DR_W  parallel value loaded on Capture-DR when IR=USER.
REQ-013 user_update_data  output  USER_DR_W  user shift register contents latched on Update-DR when IR=USER.
REQ-014 user_update_valid  output  1  one-clk_in pulse marking that user_update_data has been refreshed.
REQ-015 user_capture_strobe  output  1  one-clk_in pulse on the cycle user_capture_data is sampled.
REQ-016 tap_state  output  4  current TAP state encoding, for debug.

Function
REQ-017 jtag_tck, jtag_tms, jtag_tdi and jtag_trst shall each pass through SYNC_STAGES flops, plus one history flop on tck.
REQ-018 A TCK rising event shall be asserted when the history flop is 0 and the synchronized tck is 1; a falling event shall be asserted when the history flop is 1 and the synchronized tck is 0.
REQ-019 The TAP shall advance exactly one state per rising event, using synchronized tms, per the 16-state IEEE 1149.1 graph: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauseDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauseIR, Ex2IR, UpdIR.
REQ-020 tap_state shall encode the states 0-15 in the order listed in REQ-019.
REQ-021 On a rising event in CapIR, the 5-bit IR shift register shall load 5'b00101.
REQ-022 On a rising event in ShIR, the IR shift register shall shift right with tdi entering the MSB.
REQ-023 On UpdIR, IR shall latch the shift register; in TLR, IR shall be forced to IDCODE.
REQ-024 Instruction decode: 5'h01 IDCODE (32-bit); 5'h11 USER (USER_DR_W bits); 5'h1F and every other code select BYPASS (1 bit, captured as 0).
REQ-025 The selected DR shall capture on a rising event in CapDR and shift right LSB-first on rising events in ShDR.
REQ-026 jtag_tdo shall be updated only on a falling event, taken from the LSB of the active IR or DR shift register, and held otherwise.
REQ-027 user_capture_strobe shall pulse in the same clk_in cycle that CapDR is processed with IR=USER.
REQ-028 user_update_data and user_update_valid shall update in the clk_in cycle after the rising event processed in UpdDR with IR=USER; all other instructions shall produce no pulse.
REQ-029 If rising and falling events coincide (tck glitch shorter than a sample), only the rising event shall be acted on.
REQ-030 TCK frequency is guaranteed to be at most clk_in/4; behavior above that rate is undefined.

Reset
REQ-031 While reset is low, the TAP shall be in TLR with IR=IDCODE, all shift registers at 0, jtag_tdo=0, jtag_tdo_oe=0, user_update_data=0, and both strobes=0.
REQ-032 Synchronized jtag_trst low shall force TLR, IR=IDCODE and tdo_oe=0 within SYNC_STAGES+1 cycles, even mid-shift; user_update_data shall be retained.
REQ-033 Five rising events with tms=1 from any state shall reach TLR.

Structure
REQ-034 A shared package jtag_tap_pkg shall hold the tap_state_e enum, the IR width (5), the IR opcodes and the IR capture constant.
REQ-035 The block shall instantiate one sub-module, jtag_sync_edge, which contains the synchronizers and the edge detector.

Verification
REQ-036 Reset released, then tms=1 for 5 TCK -> tap_state=0 and IR=5'h01.
REQ-037 From RTI, go to ShDR and shift 32 bits -> tdo yields 32'h2495_11C3 LSB-first.
REQ-038 IR scan of 5'h1F, then shift DR pattern 8'hA5 -> tdo returns 0 followed by 8'hA5, delayed by one TCK.
REQ-039 IR scan shifting 5'h11 -> tdo during ShIR yields 5'b00101 LSB-first.
REQ-040 IR=USER with capture=41'h1_2345_6789A, shift in 41'h0_ABCD_EF012 -> tdo yields the capture value, and at UpdDR user_update_data=41'h0_ABCD_EF012 with one user_update_valid pulse.
REQ-041 jtag_trst pulled low mid-ShDR -> tap_state=0, tdo_oe=0, IR=IDCODE, and no update pulse.

Source files
------------

// File: rtl/jtag_tap_pkg.sv
// jtag_tap_pkg: shared TAP state encoding, IR opcodes and next-state function
package jtag_tap_pkg;
  localparam int IR_W = 5;
  localparam logic [IR_W-1:0] IR_IDCODE  = 5'h01;
  localparam logic [IR_W-1:0] IR_USER    = 5'h11;
  localparam logic [IR_W-1:0] IR_BYPASS  = 5'h1F;
  localparam logic [IR_W-1:0] IR_CAPTURE = 5'b00101;
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
  } tap_state_e;
  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    case (s)
      TLR:      tap_next = tms ? TLR      : RTI;
      RTI:      tap_next = tms ? SEL_DR   : RTI;
      SEL_DR:   tap_next = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   tap_next = tms ? EX1_DR   : SH_DR;
      SH_DR:    tap_next = tms ? EX1_DR   : SH_DR;
      EX1_DR:   tap_next = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: tap_next = tms ? EX2_DR   : PAUSE_DR;
      EX2_DR:   tap_next = tms ? UPD_DR   : SH_DR;
      UPD_DR:   tap_next = tms ? SEL_DR   : RTI;
      SEL_IR:   tap_next = tms ? TLR      : CAP_IR;
      CAP_IR:   tap_next = tms ? EX1_IR   : SH_IR;
      SH_IR:    tap_next = tms ? EX1_IR   : SH_IR;
      EX1_IR:   tap_next = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: tap_next = tms ? EX2_IR   : PAUSE_IR;
      EX2_IR:   tap_next = tms ? UPD_IR   : SH_IR;
      UPD_IR:   tap_next = tms ? SEL_DR   : RTI;
      default:  tap_next = TLR;
    endcase
  endfunction
endpackage

// File: rtl/jtag_sync_edge.sv
// jtag_sync_edge: synchronizes the JTAG pins into clk_in and detects TCK edges
module jtag_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic reset,
  input  logic tck,
  input  logic tms,
  input  logic tdi,
  input  logic trst,
  output logic tms_s,
  output logic tdi_s,
  output logic trst_s,
  output logic rise,
  output logic fall
);
  logic [3:0] sync [SYNC_STAGES];
  logic tck_s, tck_hist;
  // pin synchronizer chains {tck,tms,tdi,trst}; trst resets asserted so the TAP starts in TLR
  always_ff @(posedge clk_in or negedge reset)
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= 4'b0100;
      tck_hist <= 1'b0;
    end else begin
      sync[0] <= {tck, tms, tdi, trst};
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      tck_hist <= sync[SYNC_STAGES-1][3];
    end
  assign {tck_s, tms_s, tdi_s, trst_s} = sync[SYNC_STAGES-1];
  assign rise = !tck_hist && tck_s;
  assign fall = tck_hist && !tck_s;
endmodule

// File: rtl/jtag_tap_oversampled.sv
// jtag_tap_oversampled: IEEE 1149.1 TAP running in clk_in with oversampled TCK
module jtag_tap_oversampled
  import jtag_tap_pkg::*;
#(
  parameter logic [31:0] IDCODE_VALUE = 32'h2495_11C3,
  parameter int          SYNC_STAGES  = 2,
  parameter int          USER_DR_W    = 41
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 jtag_tck,
  input  logic                 jtag_tms,
  input  logic                 jtag_tdi,
  input  logic                 jtag_trst,
  output logic                 jtag_tdo,
  output logic                 jtag_tdo_oe,
  input  logic [USER_DR_W-1:0] user_capture_data,
  output logic [USER_DR_W-1:0] user_update_data,
  output logic                 user_update_valid,
  output logic                 user_capture_strobe,
  output logic [3:0]           tap_state
);
  tap_state_e state;
  logic [IR_W-1:0] ir, ir_sr;
  logic [31:0] idcode_sr;
  logic [USER_DR_W-1:0] user_sr;
  logic bypass_sr, tms_s, tdi_s, trst_s, rise, fall;
  logic sel_id, sel_user, sel_byp, dr_lsb;
  jtag_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_in (clk_in),
    .reset  (reset),
    .tck    (jtag_tck),
    .tms    (jtag_tms),
    .tdi    (jtag_tdi),
    .trst   (jtag_trst),
    .tms_s  (tms_s),
    .tdi_s  (tdi_s),
    .trst_s (trst_s),
    .rise   (rise),
    .fall   (fall)
  );
  assign sel_id   = ir == IR_IDCODE;
  assign sel_user = ir == IR_USER;
  assign sel_byp  = ir == IR_BYPASS || !(sel_id || sel_user);
  assign dr_lsb   = sel_id ? idcode_sr[0] : sel_user ? user_sr[0] : bypass_sr;
  assign tap_state   = state;
  assign jtag_tdo_oe = state == SH_IR || state == SH_DR;
  assign user_capture_strobe = rise && trst_s && state == CAP_DR && sel_user;
  // TAP controller: rising events advance state and move shift registers; falling events drive tdo
  always_ff @(posedge clk_in or negedge reset)
    if (!reset) begin
      state             <= TLR;
      ir                <= IR_IDCODE;
      ir_sr             <= '0;
      idcode_sr         <= '0;
      user_sr           <= '0;
      bypass_sr         <= 1'b0;
      jtag_tdo          <= 1'b0;
      user_update_data  <= '0;
      user_update_valid <= 1'b0;
    end else begin
      user_update_valid <= 1'b0;
      if (!trst_s || state == TLR) ir <= IR_IDCODE;
      if (!trst_s) state <= TLR;
      else if (rise) begin
        state <= tap_next(state, tms_s);
        if (state == CAP_IR) ir_sr <= IR_CAPTURE;
        if (state == SH_IR) ir_sr <= {tdi_s, ir_sr[IR_W-1:1]};
        if (state == UPD_IR) ir <= ir_sr;
        if (state == CAP_DR) begin
          if (sel_id) idcode_sr <= IDCODE_VALUE;
          if (sel_user) user_sr <= user_capture_data;
          if (sel_byp) bypass_sr <= 1'b0;
        end
        if (state == SH_DR) begin
          if (sel_id) idcode_sr <= {tdi_s, idcode_sr[31:1]};
          if (sel_user) user_sr <= {tdi_s, user_sr[USER_DR_W-1:1]};
          if (sel_byp) bypass_sr <= tdi_s;
        end
        if (state == UPD_DR && sel_user) begin
          user_update_data  <= user_sr;
          user_update_valid <= 1'b1;
        end
      end else if (fall) jtag_tdo <= state == SH_IR ? ir_sr[0] : dr_lsb;
    end
endmodule

// File: tb/tb_jtag_tap_oversampled.sv
// tb_jtag_tap_oversampled: table-driven state walk plus directed IR/DR scan sequences
module tb_jtag_tap_oversampled;
  logic clk_in = 1'b0, reset = 1'b0;
  logic jtag_tck = 1'b0, jtag_tms = 1'b1, jtag_tdi = 1'b0, jtag_trst = 1'b1;
  logic jtag_tdo, jtag_tdo_oe, user_update_valid, user_capture_strobe;
  logic [40:0] user_capture_data = '0, user_update_data;
  logic [3:0] tap_state;
  int n_vec = 0, n_err = 0, cap_cnt = 0, upd_cnt = 0;
  typedef struct { logic tms; logic [3:0] st; } vec_t;
  vec_t tbl [44];

  jtag_tap_oversampled dut (
    .clk_in              (clk_in),
    .reset               (reset),
    .jtag_tck            (jtag_tck),
    .jtag_tms            (jtag_tms),
    .jtag_tdi            (jtag_tdi),
    .jtag_trst           (jtag_trst),
    .jtag_tdo            (jtag_tdo),
    .jtag_tdo_oe         (jtag_tdo_oe),
    .user_capture_data   (user_capture_data),
    .user_update_data    (user_update_data),
    .user_update_valid   (user_update_valid),
    .user_capture_strobe (user_capture_strobe),
    .tap_state           (tap_state)
  );

  always #5 clk_in = ~clk_in;

  // count every clk_in cycle each strobe is high, so a stretched pulse shows up as >1
  always @(posedge clk_in) begin
    if (user_capture_strobe) cap_cnt++;
    if (user_update_valid) upd_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one TCK period of 80 ns; tdo is sampled just before the rising edge
  task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo_s);
    jtag_tms = tms;
    jtag_tdi = tdi;
    #20;
    tdo_s = jtag_tdo;
    jtag_tck = 1'b1;
    #40;
    jtag_tck = 1'b0;
    #20;
  endtask

  task automatic ir_scan(input logic [4:0] v, output logic [4:0] o);
    logic t;
    tck_cycle(1'b1, 1'b0, t);
    tck_cycle(1'b1, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
    for (int i = 0; i < 5; i++) begin
      tck_cycle(i == 4, v[i], t);
      o[i] = t;
    end
    tck_cycle(1'b1, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
  endtask

  task automatic dr_scan(input int n, input logic [63:0] v, output logic [63:0] o);
    logic t;
    o = '0;
    tck_cycle(1'b1, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
    for (int i = 0; i < n; i++) begin
      tck_cycle(i == n - 1, v[i], t);
      o[i] = t;
    end
    tck_cycle(1'b1, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
  endtask

  initial begin
    logic t;
    logic [4:0] o5;
    logic [63:0] o64;
    int c0, u0;
    tbl = '{
      '{1'b0, 4'd1},  '{1'b0, 4'd1},  '{1'b1, 4'd2},  '{1'b0, 4'd3},
      '{1'b0, 4'd4},  '{1'b0, 4'd4},  '{1'b1, 4'd5},  '{1'b0, 4'd6},
      '{1'b0, 4'd6},  '{1'b1, 4'd7},  '{1'b0, 4'd4},  '{1'b1, 4'd5},
      '{1'b1, 4'd8},  '{1'b1, 4'd2},  '{1'b1, 4'd9},  '{1'b0, 4'd10},
      '{1'b0, 4'd11}, '{1'b0, 4'd11}, '{1'b1, 4'd12}, '{1'b0, 4'd13},
      '{1'b0, 4'd13}, '{1'b1, 4'd14}, '{1'b0, 4'd11}, '{1'b1, 4'd12},
      '{1'b1, 4'd15}, '{1'b0, 4'd1},  '{1'b1, 4'd2},  '{1'b0, 4'd3},
      '{1'b1, 4'd5},  '{1'b0, 4'd6},  '{1'b1, 4'd7},  '{1'b1, 4'd8},
      '{1'b0, 4'd1},  '{1'b1, 4'd2},  '{1'b1, 4'd9},  '{1'b0, 4'd10},
      '{1'b1, 4'd12}, '{1'b0, 4'd13}, '{1'b1, 4'd14}, '{1'b1, 4'd15},
      '{1'b1, 4'd2},  '{1'b1, 4'd9},  '{1'b1, 4'd0},  '{1'b1, 4'd0}
    };
    #32;
    check("rst_state", tap_state, 0);
    check("rst_tdo", jtag_tdo, 0);
    check("rst_oe", jtag_tdo_oe, 0);
    check("rst_upd_data", user_update_data, 0);
    check("rst_upd_valid", user_update_valid, 0);
    check("rst_cap_strobe", user_capture_strobe, 0);
    reset = 1'b1;
    #40;
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, t);
    check("tlr_state", tap_state, 0);
    check("tlr_ir", dut.ir, 5'h01);
    for (int i = 0; i < 44; i++) begin
      tck_cycle(tbl[i].tms, 1'b0, t);
      check($sformatf("walk%0d_state", i), tap_state, tbl[i].st);
      check($sformatf("walk%0d_oe", i), jtag_tdo_oe, tbl[i].st == 4'd4 || tbl[i].st == 4'd11);
    end
    tck_cycle(1'b0, 1'b0, t);
    dr_scan(32, 64'h0, o64);
    check("idcode", o64, 64'h2495_11C3);
    ir_scan(5'h1F, o5);
    check("ir_cap_bypass", o5, 5'b00101);
    check("ir_bypass", dut.ir, 5'h1F);
    dr_scan(9, 64'h0A5, o64);
    check("bypass_delay", o64, 64'h14A);
    check("no_cap_pulse", cap_cnt, 0);
    check("no_upd_pulse", upd_cnt, 0);
    c0 = cap_cnt;
    u0 = upd_cnt;
    ir_scan(5'h11, o5);
    check("ir_cap_user", o5, 5'b00101);
    check("ir_user", dut.ir, 5'h11);
    user_capture_data = 41'h1_2345_6789A;
    dr_scan(41, 64'h0_ABCD_EF012, o64);
    check("user_capture", o64, 64'h1_2345_6789A);
    check("user_update", user_update_data, 64'h0_ABCD_EF012);
    check("cap_pulses", cap_cnt - c0, 1);
    check("upd_pulses", upd_cnt - u0, 1);
    tck_cycle(1'b1, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
    check("shdr_state", tap_state, 4);
    check("shdr_oe", jtag_tdo_oe, 1);
    for (int i = 0; i < 3; i++) tck_cycle(1'b0, 1'b1, t);
    jtag_trst = 1'b0;
    #60;
    check("trst_state", tap_state, 0);
    check("trst_oe", jtag_tdo_oe, 0);
    check("trst_ir", dut.ir, 5'h01);
    check("trst_no_pulse", upd_cnt - u0, 1);
    check("trst_keep_data", user_update_data, 64'h0_ABCD_EF012);
    jtag_trst = 1'b1;
    #40;
    tck_cycle(1'b0, 1'b0, t);
    tck_cycle(1'b1, 1'b0, t);
    tck_cycle(1'b1, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
    check("shir_state", tap_state, 11);
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, t);
    check("five_tms_tlr", tap_state, 0);
    tck_cycle(1'b0, 1'b0, t);
    dr_scan(32, 64'h0, o64);
    check("idcode_after_trst", o64, 64'h2495_11C3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
